s2qed_lockstep_mem: RTL and testbench
=====================================

// Module: s2qed_lockstep_mem
// PURPOSE
//  Shared AXI-lite memory responder for the S2QED harness, serving NUM_CORES identical mriscvcore copies.
//  - The k-th read of every core returns the same data, drawn once from an external symbolic stimulus port.
//  - The k-th write of every core is compared against the first core to issue it; any divergence sets a sticky mismatch flag.
//  - Replaces the tied-off AXI wiring between the duplicated cores in the S2QED top; lets cores drift up to DEPTH transactions apart.
// PARAMETERS
//  NUM_CORES   2    number of core copies served (>=2)
//  ADDR_W      32   AXI address width
//  DATA_W      32   AXI data width; strobe width = DATA_W/8
//  DEPTH       4    replay-buffer entries per path (power of 2, >=2); max drift between leading and lagging core
//  RD_LATENCY  1    cycles from AR accept to r_valid (>=1)
// PORTS
//  clk            in   1                    clock
//  rstn           in   1                    async active-low reset
//  ar_valid       in   NUM_CORES            per-core read address valid
//  ar_ready       out  NUM_CORES            per-core read address ready
//  ar_addr        in   NUM_CORES*ADDR_W     per-core read address, core c at [c*ADDR_W +: ADDR_W]
//  r_valid        out  NUM_CORES            read data valid
//  r_ready        in   NUM_CORES            read data ready
//  r_data         out  NUM_CORES*DATA_W     read data
//  aw_valid       in   NUM_CORES            write address valid
//  aw_ready       out  NUM_CORES            write address ready
//  aw_addr        in   NUM_CORES*ADDR_W     write address
//  w_valid        in   NUM_CORES            write data valid
//  w_ready        out  NUM_CORES            write data ready
//  w_data         in   NUM_CORES*DATA_W     write data
//  w_strb         in   NUM_CORES*DATA_W/8   write strobes
//  b_valid        out  NUM_CORES            write response valid (always OKAY)
//  b_ready        in   NUM_CORES            write response ready
//  stim_data      in   DATA_W               symbolic read value; sampled on stim_req
//  stim_req       out  1                    new read entry allocated this cycle
//  mismatch       out  1                    sticky: cores diverged
//  mismatch_core  out  $clog2(NUM_CORES)    lowest core index of the first detected divergence
// BEHAVIOUR
//  - Reset (async, rstn=0): all pointers = 0; r_valid, b_valid, mismatch, mismatch_core = 0; FSMs to IDLE.
//  - Each path (read, write) owns a buffer with:
//    - alloc pointer A;
//    - per-core index I[c];
//    - pointers DEPTH-modulo, width $clog2(DEPTH)+1.
//  - Leader: I[c]==A. A leader accepts only if A - min(I) < DEPTH; otherwise its ready = 0 (stall).
//  - Simultaneous leaders: only the lowest-index leader allocates that cycle. The others see I!=A next cycle and follow as laggers.
//  - Read FSM per core: R_IDLE -> R_WAIT -> R_RESP -> R_IDLE.
//    - ar_ready = (state==R_IDLE) && space-or-entry-available; combinational.
//    - Accept as leader: stim_req=1; entry = {stim_data, ar_addr}; A++.
//    - Accept as lagger: entry I[c] is read.
//    - I[c]++ on accept.
//    - R_WAIT counts RD_LATENCY-1 cycles; 0 extra when RD_LATENCY=1.
//    - R_RESP: r_valid=1 with the entry data, held stable until r_ready; then R_IDLE. No new AR is accepted while in R_WAIT or R_RESP.
//  - Write FSM per core: W_IDLE -> W_RESP -> W_IDLE.
//    - aw_ready = w_ready = 1 only in W_IDLE with aw_valid && w_valid both high and space available; AW and W are accepted in the same cycle.
//    - Leader stores {addr,data,strb}. Lagger compares all three against entry I[c].
//    - W_RESP: b_valid=1 next cycle, held until b_ready.
//  - Mismatch:
//    - On the first compare failure, mismatch <= 1 and mismatch_core <= lowest failing core in that cycle.
//    - Both remain held until reset; later failures do not update mismatch_core.
//    - Transactions continue normally after a mismatch.
//  - Buffer entry freed when all cores have passed it (min(I) advances). No entry is overwritten before being freed.
//  - Wrap: pointer MSB distinguishes full from empty; A - min(I) == DEPTH means full.
//  - Reset mid-transaction: all in-flight handshakes are dropped; valids deassert asynchronously.
// CONFIGURATION
//  - S2QED_ADDR_CHECK_EN defined: lagging reads also compare ar_addr against the stored address; a difference raises mismatch.
//  - Not defined: the read address is not stored or compared (the address field is removed from the read buffer); only writes are checked.
// STRUCTURE
//  - Package s2qed_pkg:
//    - rd_state_t {R_IDLE,R_WAIT,R_RESP};
//    - wr_state_t {W_IDLE,W_RESP};
//    - function ptr_diff(a,b) for modulo-width subtraction;
//    - constant S2QED_AXI_OKAY=2'b00.
//  - Sub-module s2qed_replay_buf (params NUM_CORES, WIDTH, DEPTH):
//    - holds A, I[], min(I), full/leader logic and entry storage;
//    - instantiated once for reads (WIDTH=DATA_W[+ADDR_W]) and once for writes (WIDTH=ADDR_W+DATA_W+DATA_W/8).
// TESTING
//  1. Both cores issue AR 0x100 in the same cycle, stim_data=0xDEADBEEF:
//     core0 allocates (stim_req=1 once); core1 is accepted 1 cycle later; both receive r_data=0xDEADBEEF.
//  2. Core0 issues 4 reads with stim 0x1..0x4 while core1 is idle (DEPTH=4):
//     core0's 5th AR sees ar_ready=0; core1 then reads 0x1..0x4 in order; core0 unstalls after core1's first read.
//  3. Both cores write addr 0x200, data 0x55, strb 0xF: b_valid for each, mismatch stays 0.
//  4. Core1 writes data 0x56 where core0 wrote 0x55: mismatch=1, mismatch_core=1 the cycle after core1's AW/W accept, held through further traffic.
//  5. Deassert rstn while core0 has r_valid=1 and r_ready=0: r_valid=0 immediately, mismatch=0; after release, core0's next read allocates entry 0 again (stim_req=1).
//  6. With S2QED_ADDR_CHECK_EN, core0 reads 0x100 and core1 reads 0x104 as the same k-th read: mismatch=1. Without the macro: no mismatch, core1 gets core0's data.

Source files
------------

// File: rtl/s2qed_lockstep_mem_pkg.sv
// Shared types and helpers for the S2QED lockstep memory responder.
package s2qed_pkg;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic       {W_IDLE, W_RESP}         wr_state_t;

  localparam logic [1:0] S2QED_AXI_OKAY = 2'b00;

  // Modulo subtraction of two pointers that are w bits wide.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned w);
    return (a - b) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/s2qed_lockstep_mem_if.sv
// Per-core AXI-lite bundle between the duplicated cores and the lockstep memory.
interface s2qed_lockstep_mem_if #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic [NUM_CORES-1:0]               ar_valid, ar_ready;
  logic [NUM_CORES-1:0][ADDR_W-1:0]   ar_addr;
  logic [NUM_CORES-1:0]               r_valid, r_ready;
  logic [NUM_CORES-1:0][DATA_W-1:0]   r_data;
  logic [NUM_CORES-1:0]               aw_valid, aw_ready;
  logic [NUM_CORES-1:0][ADDR_W-1:0]   aw_addr;
  logic [NUM_CORES-1:0]               w_valid, w_ready;
  logic [NUM_CORES-1:0][DATA_W-1:0]   w_data;
  logic [NUM_CORES-1:0][DATA_W/8-1:0] w_strb;
  logic [NUM_CORES-1:0]               b_valid, b_ready;

  modport master (
    output ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    input  ar_ready, r_valid, r_data, aw_ready, w_ready, b_valid
  );

  modport slave (
    input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    output ar_ready, r_valid, r_data, aw_ready, w_ready, b_valid
  );
endinterface

// File: rtl/s2qed_replay_buf.sv
// Replay buffer: the leading core allocates entries, lagging cores replay them in order.
module s2qed_replay_buf
  import s2qed_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_CORES-1:0]            req_i,
  input  logic [NUM_CORES-1:0][WIDTH-1:0] data_i,
  output logic [NUM_CORES-1:0]            rdy_o,
  output logic [NUM_CORES-1:0]            alloc_o,
  output logic [NUM_CORES-1:0][WIDTH-1:0] entry_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]                 a_q, a_d, lag_max, lag;
  logic [NUM_CORES-1:0][PW-1:0]  idx_q, idx_d;
  logic [DEPTH-1:0][WIDTH-1:0]   mem_q;
  logic [NUM_CORES-1:0]          lead;
  logic                          not_full, do_alloc, lead_busy;
  logic [WIDTH-1:0]              win_data;

  // The slowest core is the one furthest behind A; that distance is the occupancy.
  always_comb begin
    lag_max = '0;
    lag     = '0;
    lead    = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      lead[c] = (idx_q[c] == a_q);
      lag     = PW'(ptr_diff(32'(a_q), 32'(idx_q[c]), PW));
      if (lag > lag_max) lag_max = lag;
    end
    not_full = (lag_max < PW'(DEPTH));
  end

  // Laggers always have a valid entry; only the lowest requesting leader may allocate.
  always_comb begin
    rdy_o     = '0;
    alloc_o   = '0;
    a_d       = a_q;
    idx_d     = idx_q;
    do_alloc  = 1'b0;
    lead_busy = 1'b0;
    win_data  = data_i[0];
    for (int c = 0; c < NUM_CORES; c++) begin
      if (!lead[c]) begin
        rdy_o[c] = 1'b1;
      end else begin
        rdy_o[c]  = not_full && !lead_busy;
        lead_busy = lead_busy | req_i[c];
      end
      if (rdy_o[c] && req_i[c]) begin
        idx_d[c] = idx_q[c] + 1'b1;
        if (lead[c]) begin
          alloc_o[c] = 1'b1;
          do_alloc   = 1'b1;
          win_data   = data_i[c];
          a_d        = a_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q   <= '0;
      idx_q <= '0;
    end else begin
      a_q   <= a_d;
      idx_q <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_alloc) mem_q[a_q[IW-1:0]] <= win_data;
  end

  always_comb begin
    entry_o = '0;
    for (int c = 0; c < NUM_CORES; c++) entry_o[c] = mem_q[idx_q[c][IW-1:0]];
  end

endmodule

// File: rtl/s2qed_lockstep_mem.sv
// Lockstep AXI-lite responder: replays symbolic reads to all cores and cross-checks writes.
// Optional S2QED_ADDR_CHECK_EN also cross-checks read addresses of lagging cores.
module s2qed_lockstep_mem
  import s2qed_pkg::*;
#(
  parameter int NUM_CORES  = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  s2qed_lockstep_mem_if.slave          bus,
  input  logic [DATA_W-1:0]            stim_data,
  output logic                         stim_req,
  output logic                         mismatch,
  output logic [$clog2(NUM_CORES)-1:0] mismatch_core
);
  localparam int MCW = $clog2(NUM_CORES);
  localparam int LW  = $clog2(RD_LATENCY) + 1;
  localparam int SW  = DATA_W / 8;
  localparam int WW  = ADDR_W + DATA_W + SW;
`ifdef S2QED_ADDR_CHECK_EN
  localparam int RW  = DATA_W + ADDR_W;
`else
  localparam int RW  = DATA_W;
`endif

  rd_state_t [NUM_CORES-1:0]          rs_q, rs_d;
  logic [NUM_CORES-1:0][LW-1:0]       cnt_q, cnt_d;
  logic [NUM_CORES-1:0][DATA_W-1:0]   rdat_q, rdat_d;
  logic [NUM_CORES-1:0]               rd_req, rd_rdy, rd_alloc, rd_acc, rd_fail;
  logic [NUM_CORES-1:0][RW-1:0]       rd_in, rd_ent;

  wr_state_t [NUM_CORES-1:0]          ws_q, ws_d;
  logic [NUM_CORES-1:0]               wr_req, wr_rdy, wr_alloc, wr_acc, wr_fail;
  logic [NUM_CORES-1:0][WW-1:0]       wr_in, wr_ent;

  logic [NUM_CORES-1:0]               fail;
  logic [MCW-1:0]                     fail_idx, mc_q;
  logic                               mm_q;

  // ---------------- read path ----------------
  always_comb begin
    rd_req = '0;
    rd_in  = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      rd_req[c] = (rs_q[c] == R_IDLE) && bus.ar_valid[c];
`ifdef S2QED_ADDR_CHECK_EN
      rd_in[c]  = {stim_data, bus.ar_addr[c]};
`else
      rd_in[c]  = stim_data;
`endif
    end
  end

  s2qed_replay_buf #(.NUM_CORES(NUM_CORES), .WIDTH(RW), .DEPTH(DEPTH)) u_rd_buf (
    .clk     (clk),
    .rstn    (rstn),
    .req_i   (rd_req),
    .data_i  (rd_in),
    .rdy_o   (rd_rdy),
    .alloc_o (rd_alloc),
    .entry_o (rd_ent)
  );

  assign rd_acc   = rd_req & rd_rdy;
  assign stim_req = |rd_alloc;

  always_comb begin
    rd_fail = '0;
`ifdef S2QED_ADDR_CHECK_EN
    for (int c = 0; c < NUM_CORES; c++)
      rd_fail[c] = rd_acc[c] && !rd_alloc[c] && (rd_ent[c][ADDR_W-1:0] != bus.ar_addr[c]);
`endif
  end

  always_comb begin
    rs_d   = rs_q;
    cnt_d  = cnt_q;
    rdat_d = rdat_q;
    for (int c = 0; c < NUM_CORES; c++) begin
      case (rs_q[c])
        R_IDLE: if (rd_acc[c]) begin
          rdat_d[c] = rd_alloc[c] ? stim_data : rd_ent[c][RW-1 -: DATA_W];
          if (RD_LATENCY == 1) begin
            rs_d[c] = R_RESP;
          end else begin
            rs_d[c]  = R_WAIT;
            cnt_d[c] = LW'(1);
          end
        end
        R_WAIT: begin
          if (cnt_q[c] == LW'(RD_LATENCY - 1)) rs_d[c] = R_RESP;
          else                                 cnt_d[c] = cnt_q[c] + 1'b1;
        end
        R_RESP:  if (bus.r_ready[c]) rs_d[c] = R_IDLE;
        default: rs_d[c] = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < NUM_CORES; c++) rs_q[c] <= R_IDLE;
      cnt_q  <= '0;
      rdat_q <= '0;
    end else begin
      rs_q   <= rs_d;
      cnt_q  <= cnt_d;
      rdat_q <= rdat_d;
    end
  end

  always_comb begin
    bus.ar_ready = '0;
    bus.r_valid  = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      bus.ar_ready[c] = (rs_q[c] == R_IDLE) && rd_rdy[c];
      bus.r_valid[c]  = (rs_q[c] == R_RESP);
    end
  end

  assign bus.r_data = rdat_q;

  // ---------------- write path ----------------
  always_comb begin
    wr_req = '0;
    wr_in  = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      wr_req[c] = (ws_q[c] == W_IDLE) && bus.aw_valid[c] && bus.w_valid[c];
      wr_in[c]  = {bus.aw_addr[c], bus.w_data[c], bus.w_strb[c]};
    end
  end

  s2qed_replay_buf #(.NUM_CORES(NUM_CORES), .WIDTH(WW), .DEPTH(DEPTH)) u_wr_buf (
    .clk     (clk),
    .rstn    (rstn),
    .req_i   (wr_req),
    .data_i  (wr_in),
    .rdy_o   (wr_rdy),
    .alloc_o (wr_alloc),
    .entry_o (wr_ent)
  );

  assign wr_acc       = wr_req & wr_rdy;
  assign bus.aw_ready = wr_acc;
  assign bus.w_ready  = wr_acc;

  always_comb begin
    wr_fail = '0;
    for (int c = 0; c < NUM_CORES; c++)
      wr_fail[c] = wr_acc[c] && !wr_alloc[c] && (wr_ent[c] != wr_in[c]);
  end

  always_comb begin
    ws_d = ws_q;
    for (int c = 0; c < NUM_CORES; c++) begin
      case (ws_q[c])
        W_IDLE:  if (wr_acc[c])      ws_d[c] = W_RESP;
        W_RESP:  if (bus.b_ready[c]) ws_d[c] = W_IDLE;
        default: ws_d[c] = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) for (int c = 0; c < NUM_CORES; c++) ws_q[c] <= W_IDLE;
    else       ws_q <= ws_d;
  end

  always_comb begin
    bus.b_valid = '0;
    for (int c = 0; c < NUM_CORES; c++) bus.b_valid[c] = (ws_q[c] == W_RESP);
  end

  // ---------------- divergence flag ----------------
  assign fail = wr_fail | rd_fail;

  always_comb begin
    fail_idx = '0;
    for (int c = NUM_CORES - 1; c >= 0; c--) if (fail[c]) fail_idx = MCW'(c);
  end

  // First failure wins; the reported core is frozen until reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mm_q <= 1'b0;
      mc_q <= '0;
    end else if (!mm_q && |fail) begin
      mm_q <= 1'b1;
      mc_q <= fail_idx;
    end
  end

  assign mismatch      = mm_q;
  assign mismatch_core = mc_q;

endmodule

// File: tb/tb_s2qed_lockstep_mem.sv
// Directed bench for the lockstep memory: read replay, stall, write compare, reset.
module tb_s2qed_lockstep_mem;
  localparam int NC = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] stim_data;
  logic          stim_req, mismatch;
  logic [0:0]    mismatch_core;
  int            checks = 0;
  int            errors = 0;

  s2qed_lockstep_mem_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();

  s2qed_lockstep_mem #(
    .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .RD_LATENCY(1)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .bus           (bus.slave),
    .stim_data     (stim_data),
    .stim_req      (stim_req),
    .mismatch      (mismatch),
    .mismatch_core (mismatch_core)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          core;
    logic [31:0] addr;
    logic [31:0] stim;
    logic [31:0] exp;
    logic        sreq;
  } rd_vec_t;

  typedef struct {
    int          core;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        mm;
    logic        mc;
  } wr_vec_t;

  rd_vec_t rd_tab[8];
  wr_vec_t wr_tab[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input rd_vec_t v, input string nm);
    int n;
    bus.ar_valid[v.core] = 1'b1;
    bus.ar_addr[v.core]  = v.addr;
    stim_data            = v.stim;
    #1;
    n = 0;
    while (!bus.ar_ready[v.core] && n < 20) begin tick(); #1; n++; end
    chk({nm, ".ar_ready"}, 32'(bus.ar_ready[v.core]), 32'd1);
    chk({nm, ".stim_req"}, 32'(stim_req), 32'(v.sreq));
    tick();
    bus.ar_valid[v.core] = 1'b0;
    n = 0;
    while (!bus.r_valid[v.core] && n < 20) begin tick(); n++; end
    chk({nm, ".r_valid"}, 32'(bus.r_valid[v.core]), 32'd1);
    chk({nm, ".r_data"}, bus.r_data[v.core], v.exp);
    bus.r_ready[v.core] = 1'b1;
    tick();
    bus.r_ready[v.core] = 1'b0;
  endtask

  task automatic do_write(input wr_vec_t v, input string nm);
    int n;
    bus.aw_valid[v.core] = 1'b1;
    bus.w_valid[v.core]  = 1'b1;
    bus.aw_addr[v.core]  = v.addr;
    bus.w_data[v.core]   = v.data;
    bus.w_strb[v.core]   = v.strb;
    #1;
    n = 0;
    while (!bus.aw_ready[v.core] && n < 20) begin tick(); #1; n++; end
    chk({nm, ".aw_ready"}, 32'(bus.aw_ready[v.core]), 32'd1);
    chk({nm, ".w_ready"}, 32'(bus.w_ready[v.core]), 32'd1);
    tick();
    bus.aw_valid[v.core] = 1'b0;
    bus.w_valid[v.core]  = 1'b0;
    chk({nm, ".b_valid"}, 32'(bus.b_valid[v.core]), 32'd1);
    chk({nm, ".mismatch"}, 32'(mismatch), 32'(v.mm));
    chk({nm, ".mismatch_core"}, 32'(mismatch_core), 32'(v.mc));
    bus.b_ready[v.core] = 1'b1;
    tick();
    bus.b_ready[v.core] = 1'b0;
    chk({nm, ".b_done"}, 32'(bus.b_valid[v.core]), 32'd0);
  endtask

  initial begin
    rd_tab[0] = '{0, 32'h10, 32'h1, 32'h1, 1'b1};
    rd_tab[1] = '{0, 32'h14, 32'h2, 32'h2, 1'b1};
    rd_tab[2] = '{0, 32'h18, 32'h3, 32'h3, 1'b1};
    rd_tab[3] = '{0, 32'h1C, 32'h4, 32'h4, 1'b1};
    rd_tab[4] = '{1, 32'h14, 32'h0, 32'h2, 1'b0};
    rd_tab[5] = '{1, 32'h18, 32'h0, 32'h3, 1'b0};
    rd_tab[6] = '{1, 32'h1C, 32'h0, 32'h4, 1'b0};
    rd_tab[7] = '{1, 32'h20, 32'h0, 32'h5, 1'b0};

    wr_tab[0] = '{0, 32'h200, 32'h55, 4'hF, 1'b0, 1'b0};
    wr_tab[1] = '{1, 32'h200, 32'h55, 4'hF, 1'b0, 1'b0};
    wr_tab[2] = '{0, 32'h204, 32'h55, 4'hF, 1'b0, 1'b0};
    wr_tab[3] = '{1, 32'h204, 32'h56, 4'hF, 1'b1, 1'b1};
    wr_tab[4] = '{0, 32'h208, 32'h77, 4'h3, 1'b1, 1'b1};
    wr_tab[5] = '{1, 32'h208, 32'h77, 4'h3, 1'b1, 1'b1};
    wr_tab[6] = '{1, 32'h20C, 32'h11, 4'hF, 1'b1, 1'b1};
    wr_tab[7] = '{0, 32'h20C, 32'h12, 4'hF, 1'b1, 1'b1};

    bus.ar_valid = '0; bus.ar_addr = '0; bus.r_ready = '0;
    bus.aw_valid = '0; bus.aw_addr = '0; bus.w_valid = '0;
    bus.w_data   = '0; bus.w_strb  = '0; bus.b_ready = '0;
    stim_data    = '0;

    #3;
    chk("rst.r_valid", 32'(bus.r_valid), 32'd0);
    chk("rst.b_valid", 32'(bus.b_valid), 32'd0);
    chk("rst.mismatch", 32'(mismatch), 32'd0);
    chk("rst.mismatch_core", 32'(mismatch_core), 32'd0);
    chk("rst.stim_req", 32'(stim_req), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // simultaneous leaders: core0 allocates, core1 follows one cycle later
    bus.ar_valid   = 2'b11;
    bus.ar_addr[0] = 32'h100;
    bus.ar_addr[1] = 32'h100;
    stim_data      = 32'hDEADBEEF;
    #1;
    chk("t1.ar_ready", 32'(bus.ar_ready), 32'd1);
    chk("t1.stim_req", 32'(stim_req), 32'd1);
    tick();
    bus.ar_valid[0] = 1'b0;
    stim_data       = 32'h0;
    #1;
    chk("t1.rvalid0", 32'(bus.r_valid), 32'd1);
    chk("t1.rdata0", bus.r_data[0], 32'hDEADBEEF);
    chk("t1.ar_ready1", 32'(bus.ar_ready[1]), 32'd1);
    chk("t1.stim_req_lag", 32'(stim_req), 32'd0);
    bus.r_ready[0] = 1'b1;
    tick();
    bus.ar_valid[1] = 1'b0;
    bus.r_ready[0]  = 1'b0;
    chk("t1.rvalid1", 32'(bus.r_valid), 32'd2);
    chk("t1.rdata1", bus.r_data[1], 32'hDEADBEEF);
    bus.r_ready[1] = 1'b1;
    tick();
    bus.r_ready[1] = 1'b0;
    chk("t1.rvalid_done", 32'(bus.r_valid), 32'd0);

    // core0 runs DEPTH reads ahead, then stalls until core1 catches up
    for (int i = 0; i < 4; i++) do_read(rd_tab[i], $sformatf("t2.lead%0d", i));
    bus.ar_valid[0] = 1'b1;
    bus.ar_addr[0]  = 32'h20;
    stim_data       = 32'h5;
    #1;
    chk("t2.stall", 32'(bus.ar_ready[0]), 32'd0);
    chk("t2.stall_sreq", 32'(stim_req), 32'd0);
    tick();
    chk("t2.stall_hold", 32'(bus.ar_ready[0]), 32'd0);
    bus.ar_valid[1] = 1'b1;
    bus.ar_addr[1]  = 32'h10;
    #1;
    chk("t2.lag_ready", 32'(bus.ar_ready), 32'd2);
    chk("t2.lag_sreq", 32'(stim_req), 32'd0);
    tick();
    bus.ar_valid[1] = 1'b0;
    #1;
    chk("t2.unstall", 32'(bus.ar_ready[0]), 32'd1);
    chk("t2.unstall_sreq", 32'(stim_req), 32'd1);
    chk("t2.lag_rdata", bus.r_data[1], 32'h1);
    tick();
    bus.ar_valid[0] = 1'b0;
    chk("t2.both_rvalid", 32'(bus.r_valid), 32'd3);
    chk("t2.lead_rdata", bus.r_data[0], 32'h5);
    chk("t2.lag_rdata_held", bus.r_data[1], 32'h1);
    bus.r_ready = 2'b11;
    tick();
    bus.r_ready = 2'b00;
    for (int i = 4; i < 8; i++) do_read(rd_tab[i], $sformatf("t2.lag%0d", i));

    // matching and diverging writes
    for (int i = 0; i < 8; i++) do_write(wr_tab[i], $sformatf("wr%0d", i));

    // reset in the middle of a pending read response
    bus.ar_valid[0] = 1'b1;
    bus.ar_addr[0]  = 32'h300;
    stim_data       = 32'hAAAA5555;
    tick();
    bus.ar_valid[0] = 1'b0;
    chk("t5.pre_rvalid", 32'(bus.r_valid[0]), 32'd1);
    chk("t5.pre_mismatch", 32'(mismatch), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t5.rvalid_async", 32'(bus.r_valid), 32'd0);
    chk("t5.mismatch_clr", 32'(mismatch), 32'd0);
    chk("t5.mcore_clr", 32'(mismatch_core), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    do_read('{0, 32'h300, 32'h1234, 32'h1234, 1'b1}, "t5.realloc");
    do_read('{1, 32'h300, 32'h0, 32'h1234, 1'b0}, "t5.replay");
    chk("t5.no_mismatch", 32'(mismatch), 32'd0);

    // k-th reads with differing addresses
    do_read('{0, 32'h100, 32'hCAFE0006, 32'hCAFE0006, 1'b1}, "t6.lead");
    do_read('{1, 32'h104, 32'h0, 32'hCAFE0006, 1'b0}, "t6.lag");
`ifdef S2QED_ADDR_CHECK_EN
    chk("t6.mismatch", 32'(mismatch), 32'd1);
    chk("t6.mcore", 32'(mismatch_core), 32'd1);
`else
    chk("t6.mismatch", 32'(mismatch), 32'd0);
    chk("t6.mcore", 32'(mismatch_core), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
